// File: rtl/ciphertext_buffer.sv
// rtl/ciphertext_buffer.sv - in-order FWFT byte FIFO for Z_227 ciphertext, optional CIPHERTEXT_BUFFER_CHECKSUM_EN checksum
module ciphertext_buffer #(
  parameter int DEPTH = 16,
  parameter int P     = 227
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               char_ciphertext,
  input  logic                     c_ready,
  input  logic                     err_invalid_ptxt,
  input  logic                     clear,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_overflow,
  output logic                     err_range
`ifdef CIPHERTEXT_BUFFER_CHECKSUM_EN
  ,
  output logic [7:0]               checksum
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [8:0] P9 = 9'(P);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          err_overflow_q;
  logic          err_range_q;

  logic wr_req;
  logic in_range;
  logic pop;
  logic wr_en;

  assign wr_req   = c_ready && !err_invalid_ptxt;
  assign in_range = ({1'b0, char_ciphertext} < P9);

  // Status flags come straight from the count register, never from c_ready
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_C);
  assign out_valid  = !fifo_empty;
  assign count      = count_q;
  assign err_overflow = err_overflow_q;
  assign err_range    = err_range_q;

  // A full FIFO can still take a byte when the head leaves the same cycle
  assign pop   = out_valid && out_ready;
  assign wr_en = wr_req && in_range && (!fifo_full || pop);

  // First-word-fall-through head, masked so an empty FIFO shows zero
  always_comb begin
    out_data = 8'h00;
    if (!fifo_empty) out_data = mem[rd_ptr];
  end

  // Storage array; contents are never reset, occupancy is tracked by count_q
  always_ff @(posedge clk) begin
    if (wr_en && !clear) mem[wr_ptr] <= char_ciphertext;
  end

  // Pointers and occupancy; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      if (wr_en && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !wr_en) count_q <= count_q - CW'(1);
    end
  end

  // Sticky error flags, released only by clear or reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_overflow_q <= 1'b0;
      err_range_q    <= 1'b0;
    end else if (clear) begin
      err_overflow_q <= 1'b0;
      err_range_q    <= 1'b0;
    end else begin
      if (wr_req && !in_range)                      err_range_q    <= 1'b1;
      if (wr_req && in_range && fifo_full && !pop)  err_overflow_q <= 1'b1;
    end
  end

`ifdef CIPHERTEXT_BUFFER_CHECKSUM_EN
  logic [7:0] checksum_q;
  logic [8:0] sum9;
  logic [8:0] sum_mod;

  // Both operands are below P, so a single conditional subtract reduces mod P
  always_comb begin
    sum9    = {1'b0, checksum_q} + {1'b0, char_ciphertext};
    sum_mod = sum9;
    if (sum9 >= P9) sum_mod = sum9 - P9;
  end

  // Running mod-P sum of accepted bytes only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      checksum_q <= 8'h00;
    else if (clear)  checksum_q <= 8'h00;
    else if (wr_en)  checksum_q <= sum_mod[7:0];
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_ciphertext_buffer.sv
// tb/tb_ciphertext_buffer.sv - scoreboard bench for ciphertext_buffer
module tb_ciphertext_buffer;

  localparam int DEPTH = 16;
  localparam int P     = 227;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] char_ciphertext = 8'h00;
  logic       c_ready = 1'b0;
  logic       err_invalid_ptxt = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       fifo_full;
  logic       fifo_empty;
  logic [4:0] count;
  logic       err_overflow;
  logic       err_range;
`ifdef CIPHERTEXT_BUFFER_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  ciphertext_buffer #(.DEPTH(DEPTH), .P(P)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .char_ciphertext(char_ciphertext),
    .c_ready(c_ready),
    .err_invalid_ptxt(err_invalid_ptxt),
    .clear(clear),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .fifo_full(fifo_full),
    .fifo_empty(fifo_empty),
    .count(count),
    .err_overflow(err_overflow),
    .err_range(err_range)
`ifdef CIPHERTEXT_BUFFER_CHECKSUM_EN
    ,
    .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model: contents as a queue of bytes, plus occupancy and flags
  logic [7:0] exp_q[$];
  int         m_cnt = 0;
  bit         m_ovf = 0;
  bit         m_rng = 0;
  int         m_cks = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // model update at each commit edge, from the inputs the bench applied
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_cnt = 0; m_ovf = 0; m_rng = 0; m_cks = 0;
    end else if (clear) begin
      exp_q.delete();
      m_cnt = 0; m_ovf = 0; m_rng = 0; m_cks = 0;
    end else begin
      bit popm, acc;
      popm = out_ready && (m_cnt > 0);
      acc  = 0;
      if (c_ready && !err_invalid_ptxt) begin
        if (int'(char_ciphertext) >= P) m_rng = 1;
        else if (m_cnt < DEPTH || popm) acc = 1;
        else m_ovf = 1;
      end
      if (acc) begin
        exp_q.push_back(char_ciphertext);
        m_cks = (m_cks + int'(char_ciphertext)) % P;
      end
      m_cnt = m_cnt + int'(acc) - int'(popm);
    end
  end

  // monitor: pops the scoreboard on each observed handshake, checks status
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_output", int'(out_data), -1);
      else chk("out_data", int'(out_data), int'(exp_q.pop_front()));
    end
    chk("count", int'(count), m_cnt);
    chk("out_valid", int'(out_valid), int'(m_cnt > 0));
    chk("fifo_full", int'(fifo_full), int'(m_cnt == DEPTH));
    chk("fifo_empty", int'(fifo_empty), int'(m_cnt == 0));
    chk("err_overflow", int'(err_overflow), int'(m_ovf));
    chk("err_range", int'(err_range), int'(m_rng));
    if (m_cnt == 0) chk("out_data_empty", int'(out_data), 0);
`ifdef CIPHERTEXT_BUFFER_CHECKSUM_EN
    chk("checksum", int'(checksum), m_cks);
`endif
  end

  // apply one cycle of inputs, then sit 1 ns after the committing edge
  task automatic cyc(input bit cr, input logic [7:0] d, input bit inv, input bit ordy, input bit clr);
    c_ready = cr; char_ciphertext = d; err_invalid_ptxt = inv;
    out_ready = ordy; clear = clr;
    @(posedge clk); #1;
    c_ready = 0; clear = 0; err_invalid_ptxt = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_empty", int'(fifo_empty), 1);
    chk("rst_full", int'(fifo_full), 0);
    chk("rst_flags", int'({err_overflow, err_range}), 0);
    rst_n = 1;

    // three bytes, held, then drained in order
    cyc(1, 8'h10, 0, 0, 0);
    cyc(1, 8'h20, 0, 0, 0);
    cyc(1, 8'h30, 0, 0, 0);
    chk("t1_count", int'(count), 3);
    chk("t1_head", int'(out_data), 8'h10);
    repeat (3) cyc(0, 8'h00, 0, 1, 0);
    chk("t1_empty", int'(fifo_empty), 1);
    chk("t1_data0", int'(out_data), 0);

    // overflow: 17 writes into 16 slots
    for (int i = 0; i < 17; i++) cyc(1, 8'(i), 0, 0, 0);
    chk("t2_full", int'(fifo_full), 1);
    chk("t2_ovf", int'(err_overflow), 1);
    repeat (16) cyc(0, 8'h00, 0, 1, 0);
    chk("t2_ovf_sticky", int'(err_overflow), 1);
    cyc(0, 8'h00, 0, 0, 1);
    chk("t2_clr_ovf", int'(err_overflow), 0);

    // full plus simultaneous write and pop
    for (int i = 0; i < 16; i++) cyc(1, 8'(i + 100), 0, 0, 0);
    cyc(1, 8'h05, 0, 1, 0);
    chk("t3_count", int'(count), 16);
    chk("t3_ovf", int'(err_overflow), 0);
    repeat (16) cyc(0, 8'h00, 0, 1, 0);
    chk("t3_empty", int'(fifo_empty), 1);

    // range boundary and invalid-plaintext qualifier
    cyc(1, 8'hE3, 0, 0, 0);
    chk("t4_rng", int'(err_range), 1);
    chk("t4_cnt0", int'(count), 0);
    cyc(1, 8'hE2, 0, 0, 0);
    chk("t4_cnt1", int'(count), 1);
    cyc(1, 8'h07, 1, 0, 0);
    chk("t4_inv_cnt", int'(count), 1);
    chk("t4_inv_ovf", int'(err_overflow), 0);
    cyc(0, 8'h00, 0, 0, 1);

    // randomized interleaving, wrapping the pointers many times
    for (int i = 0; i < 400; i++) begin
      logic [7:0] d;
      d = 8'($urandom_range(0, 255));
      cyc(($urandom % 2) == 1, d, ($urandom % 10) == 0,
          ($urandom % 3) != 0, ($urandom % 60) == 0);
    end
    cyc(1, 8'h44, 0, 1, 1);
    chk("t5_clr_cnt", int'(count), 0);
    chk("t5_clr_flags", int'({err_overflow, err_range}), 0);
    chk("t5_clr_empty", int'(fifo_empty), 1);

`ifdef CIPHERTEXT_BUFFER_CHECKSUM_EN
    cyc(1, 8'hC8, 0, 0, 0);
    chk("t6_cks200", int'(checksum), 200);
    cyc(1, 8'h64, 0, 0, 0);
    chk("t6_cks73", int'(checksum), 73);
    cyc(1, 8'hF0, 0, 0, 0);
    chk("t6_cks_drop", int'(checksum), 73);
    cyc(0, 8'h00, 0, 0, 1);
    chk("t6_cks_clr", int'(checksum), 0);
`endif

    // asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) cyc(1, 8'(i + 50), 0, 0, 0);
    #1 rst_n = 0;
    #1;
    chk("t7_rst_cnt", int'(count), 0);
    chk("t7_rst_valid", int'(out_valid), 0);
    chk("t7_rst_data", int'(out_data), 0);
    chk("t7_rst_empty", int'(fifo_empty), 1);
    @(posedge clk); #1;
    rst_n = 1;
    cyc(1, 8'h99, 0, 0, 0);
    chk("t7_after_cnt", int'(count), 1);
    chk("t7_after_head", int'(out_data), 8'h99);
    repeat (3) cyc(0, 8'h00, 0, 1, 0);
    chk("final_sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
